// File: rtl/pattern_generator.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit word out MSB-first,
// repeat_n times with gap_len idle cycles between repetitions.
module pattern_generator #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 16,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_n_i,
    input  logic [GAP_W-1:0] gap_len_i,
    output logic             dout_o,
    output logic             dout_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sent_cnt_o
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q <= S_IDLE;
            sent_q  <= '0;
            dout_q  <= IDLE_LVL;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Latched transfer parameters and counters are only meaningful once a start
    // has loaded them, so they carry no reset.
    always_ff @(posedge clk) begin
        pat_q     <= pat_d;
        rep_q     <= rep_d;
        gap_q     <= gap_d;
        gap_cnt_q <= gap_cnt_d;
        idx_q     <= idx_d;
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        sent_d    = sent_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pat_d   = pattern_i;
                    rep_d   = repeat_n_i;
                    gap_d   = gap_len_i;
                    sent_d  = '0;
                    idx_d   = IDX_TOP;
                    state_d = (repeat_n_i != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (idx_q == '0) begin
                    sent_d = sent_q + CNT_ONE;
                    if (sent_d == rep_q) begin
                        state_d = S_DONE;
                    end else if (gap_q == '0) begin
                        idx_d = IDX_TOP;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_q - GAP_ONE;
                    end
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            S_GAP: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_SHIFT;
                    idx_d   = IDX_TOP;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        dout_d = (state_d == S_SHIFT) ? pat_d[idx_d] : IDLE_LVL;
        dv_d   = (state_d == S_SHIFT);
        busy_d = (state_d == S_SHIFT) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dv_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sent_cnt_o   = sent_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: directed scenarios plus random transfers, each
// compared cycle-by-cycle against an expected stream built from the rules.
module tb_pattern_generator;

    localparam int PAT_W = 4;
    localparam int CNT_W = 16;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             srst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_n = '0;
    logic [GAP_W-1:0] gap_len = '0;
    logic             dout, dout_valid, busy, done;
    logic [CNT_W-1:0] sent_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic             d;
        logic             v;
        logic             b;
        logic             dn;
        logic [CNT_W-1:0] s;
    } obs_t;

    pattern_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_LVL(1'b1)) dut (
        .clk          (clk),
        .srst_n       (srst_n),
        .start_i      (start),
        .abort_i      (abort),
        .pattern_i    (pattern),
        .repeat_n_i   (repeat_n),
        .gap_len_i    (gap_len),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .busy_o       (busy),
        .done_o       (done),
        .sent_cnt_o   (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t idle_obs(input int cnt);
        obs_t o;
        o.d = 1'b1; o.v = 1'b0; o.b = 1'b0; o.dn = 1'b0; o.s = CNT_W'(cnt);
        return o;
    endfunction

    task automatic chk(input string tag, input obs_t exp);
        obs_t o;
        o.d = dout; o.v = dout_valid; o.b = busy; o.dn = done; o.s = sent_cnt;
        n_assert++;
        assert (o === exp) else begin
            n_fail++;
            $error("FAIL %s observed dout=%b vld=%b busy=%b done=%b cnt=%0d expected dout=%b vld=%b busy=%b done=%b cnt=%0d",
                   tag, o.d, o.v, o.b, o.dn, o.s, exp.d, exp.v, exp.b, exp.dn, exp.s);
        end
    endtask

    // Build the expected per-cycle stream, then drive one transfer and compare.
    // abort_at / sb_at / rst_at select the cycle index for an abort, a start
    // while busy, or a reset (-1 = none).
    task automatic run_txn(input string name, input logic [PAT_W-1:0] p, input int rep,
                           input int gap, input int abort_at, input int sb_at, input int rst_at);
        obs_t q[$];
        int   comp_end[$];
        obs_t e;
        int   ab;
        q.delete();
        comp_end.delete();
        for (int r = 0; r < rep; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                if (b == 0) comp_end.push_back(q.size());
                e.d = p[b]; e.v = 1'b1; e.b = 1'b1; e.dn = 1'b0; e.s = '0;
                q.push_back(e);
            end
            if (r < rep - 1) begin
                for (int g = 0; g < gap; g++) begin
                    e.d = 1'b1; e.v = 1'b0; e.b = 1'b1; e.dn = 1'b0; e.s = '0;
                    q.push_back(e);
                end
            end
        end
        e.d = 1'b1; e.v = 1'b0; e.b = 1'b0; e.dn = 1'b1; e.s = '0;
        q.push_back(e);
        for (int i = 0; i < q.size(); i++) begin
            int c = 0;
            foreach (comp_end[k]) if (comp_end[k] < i) c++;
            q[i].s = CNT_W'(c);
        end
        ab = abort_at;
        foreach (comp_end[k]) if (comp_end[k] == ab) ab = -1;

        pattern  = p;
        repeat_n = CNT_W'(rep);
        gap_len  = GAP_W'(gap);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        pattern  = PAT_W'($urandom);
        repeat_n = CNT_W'($urandom_range(1, 9));
        gap_len  = GAP_W'($urandom);

        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("%s_c%0d", name, i), q[i]);
            if (i == ab) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk($sformatf("%s_abort", name), idle_obs(q[i].s));
                tick();
                chk($sformatf("%s_abort_hold", name), idle_obs(q[i].s));
                return;
            end else if (i == rst_at) begin
                srst_n = 1'b0;
                start  = 1'b1;
                tick();
                srst_n = 1'b1;
                start  = 1'b0;
                chk($sformatf("%s_rst", name), idle_obs(0));
                tick();
                chk($sformatf("%s_rst_nostart", name), idle_obs(0));
                return;
            end else if (i == sb_at) begin
                start    = 1'b1;
                pattern  = ~p;
                repeat_n = CNT_W'(7);
                tick();
                start    = 1'b0;
            end else begin
                tick();
            end
        end
        chk($sformatf("%s_idle", name), idle_obs(rep));
        tick();
        chk($sformatf("%s_hold", name), idle_obs(rep));
    endtask

    initial begin
        srst_n = 1'b0;
        start  = 1'b1;
        tick();
        tick();
        chk("reset", idle_obs(0));
        srst_n = 1'b1;
        start  = 1'b0;
        tick();
        chk("post_reset_idle", idle_obs(0));

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_idle", idle_obs(0));

        run_txn("b2b",      4'b0110, 3, 0, -1, -1, -1);
        run_txn("gap",      4'b1010, 2, 3, -1, -1, -1);
        run_txn("zero_rep", 4'b1111, 0, 2, -1, -1, -1);
        run_txn("abort",    4'b0110, 4, 0,  6, -1, -1);
        run_txn("after_ab", 4'b0110, 2, 1, -1, -1, -1);
        run_txn("start_bz", 4'b0110, 3, 0, -1,  5, -1);
        run_txn("start_dn", 4'b1001, 1, 0, -1,  4, -1);
        run_txn("rst_mid",  4'b1100, 3, 2, -1, -1,  2);
        run_txn("abort_gap",4'b0011, 3, 2,  4, -1, -1);

        for (int k = 0; k < 12; k++) begin
            logic [PAT_W-1:0] p;
            int rep, gap, len, ab, sb;
            p   = PAT_W'($urandom);
            rep = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            len = rep * PAT_W + ((rep > 0) ? (rep - 1) * gap : 0) + 1;
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            sb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            if (sb == ab) sb = -1;
            run_txn($sformatf("rnd%0d", k), p, rep, gap, ab, sb, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
